// File: rtl/rr_grant_arbiter_pkg.sv
// rr_grant_arbiter_pkg
// Shared definitions for the round-robin grant arbiter:
//   - NUM_REQ / IDX_W : requester count and owner index width
//   - state_e         : arbiter state encoding (IDLE=0, GRANT=1)
//   - rr_pick()       : first set request bit searching from a start pointer
package rr_grant_arbiter_pkg;

  localparam int NUM_REQ = 4;
  localparam int IDX_W   = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  // Circular priority search: ptr has top priority, then ptr+1, ... wrapping
  // naturally through the IDX_W-bit index arithmetic.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                               input logic [IDX_W-1:0]   ptr);
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] pick;
    logic             found;
    pick  = ptr;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = ptr + IDX_W'(k);
      if (!found && req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/rr_grant_arbiter_if.sv
// rr_grant_arbiter_if
// Request/grant bundle between requesters and the arbiter.
//   enabler : permits new grants (does not affect an existing grant)
//   req     : per-requester request, held high while the resource is wanted
//   gnt     : registered one-hot grant, zero when nobody owns the resource
//   gnt_id  : binary index of the owner, zero when gnt is zero
//   busy    : high exactly when gnt is non-zero
// Modports: master = requester side, slave = arbiter side.
interface rr_grant_arbiter_if;
  import rr_grant_arbiter_pkg::*;

  logic               enabler;
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] gnt;
  logic [IDX_W-1:0]   gnt_id;
  logic               busy;

  modport master (output enabler, output req,
                  input  gnt, input gnt_id, input busy);

  modport slave  (input  enabler, input req,
                  output gnt, output gnt_id, output busy);

endinterface

// File: rtl/rr_grant_arbiter_decode.sv
// grant_decode_2to4
// Turns the owner index into the one-hot grant vector.
//   idx    : owner index
//   en     : gate; output is all-zero when low
//   onehot : decoded one-hot grant
module grant_decode_2to4
  import rr_grant_arbiter_pkg::*;
(
  input  logic [IDX_W-1:0]   idx,
  input  logic               en,
  output logic [NUM_REQ-1:0] onehot
);

  always_comb begin
    onehot = '0;
    if (en) onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/rr_grant_arbiter.sv
// rr_grant_arbiter
// Four-requester round-robin arbiter with a two-state FSM (IDLE/GRANT).
// An owner keeps the resource while its request stays high; on release the
// round-robin pointer moves past it and at least one IDLE cycle follows.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : rr_grant_arbiter_if.slave (enabler, req in; gnt, gnt_id, busy out)
// Parameter:
//   MAX_HOLD : consecutive granted cycles before a forced release (2..255)
// Configuration macro:
//   ARB_HOLD_LIMIT_EN : when defined, an owner that has held the grant for
//                       MAX_HOLD cycles is released if anyone else requests.
//                       When undefined the hold counter is not built.
module rr_grant_arbiter
  import rr_grant_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  rr_grant_arbiter_if.slave  bus
);

  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("rr_grant_arbiter: MAX_HOLD must lie in 2..255");
  end

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q,   ptr_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [NUM_REQ-1:0] gnt_q,   gnt_d;
  logic               release_now;

`ifdef ARB_HOLD_LIMIT_EN
  localparam logic [7:0] HOLD_MAX = 8'(MAX_HOLD);
  logic [7:0] hcnt_q, hcnt_d;
`endif

  // The owner index is cleared on release so gnt_id reads 0 whenever idle.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    release_now = 1'b0;
`ifdef ARB_HOLD_LIMIT_EN
    hcnt_d      = hcnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.enabler && (|bus.req)) begin
          state_d = GRANT;
          owner_d = rr_pick(bus.req, ptr_q);
`ifdef ARB_HOLD_LIMIT_EN
          hcnt_d  = 8'd1;
`endif
        end
      end
      GRANT: begin
        release_now = !bus.req[owner_q];
`ifdef ARB_HOLD_LIMIT_EN
        // gnt_q is the owner's one-hot, so req & ~gnt_q is everyone else.
        if ((hcnt_q == HOLD_MAX) && (|(bus.req & ~gnt_q))) release_now = 1'b1;
`endif
        if (release_now) begin
          state_d = IDLE;
          ptr_d   = owner_q + 2'd1;
          owner_d = '0;
`ifdef ARB_HOLD_LIMIT_EN
          hcnt_d  = 8'd0;
`endif
        end
`ifdef ARB_HOLD_LIMIT_EN
        else if (hcnt_q != HOLD_MAX) begin
          hcnt_d = hcnt_q + 8'd1;
        end
`endif
      end
      default: begin
        state_d = IDLE;
        owner_d = '0;
      end
    endcase
  end

  // Decode the next owner so the grant itself is a flop.
  grant_decode_2to4 u_decode (
    .idx    (owner_d),
    .en     (state_d == GRANT),
    .onehot (gnt_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      gnt_q   <= gnt_d;
    end
  end

`ifdef ARB_HOLD_LIMIT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hcnt_q <= 8'd0;
    else        hcnt_q <= hcnt_d;
  end
`endif

  assign bus.gnt    = gnt_q;
  assign bus.gnt_id = owner_q;
  assign bus.busy   = (state_q == GRANT);

endmodule

// File: doc/rr_grant_arbiter.md
RR_GRANT_ARBITER -- requirements
Module: rr_grant_arbiter

Interface
REQ-001 Parameter MAX_HOLD, default 8, is the maximum number of consecutive granted cycles before a forced release; legal range 2..255.
REQ-002 Port clk, input, 1, is the single clock; all state updates on its rising edge.
REQ-003 Port rst_n, input, 1, is the reset: asynchronous, active-low.
REQ-004 Port enabler, input, 1: when high, new grants are permitted; an existing grant is not affected.
REQ-005 Port req, input, 4: req[i] high means requester i wants the shared resource and holds it while high.
REQ-006 Port gnt, output, 4: one-hot grant, registered; all-zero when nobody owns the resource.
REQ-007 Port gnt_id, output, 2: binary index of the current owner; 0 when gnt is zero.
REQ-008 Port busy, output, 1: high exactly when gnt is non-zero.

Function
REQ-009 The state machine SHALL have two states, IDLE and GRANT, plus a 2-bit round-robin pointer ptr and a hold counter hcnt.
REQ-010 In IDLE with enabler=1 and req!=0, the next state SHALL be GRANT, with owner = first i with req[i]=1 searching ptr, ptr+1, ... mod 4.
REQ-011 Grant latency SHALL be one cycle: req sampled at edge N gives gnt valid after edge N.
REQ-012 gnt SHALL equal the 2-to-4 decode of gnt_id gated by busy; at most one gnt bit is ever high.
REQ-013 In IDLE with enabler=0 or req=0, the block SHALL remain in IDLE with gnt=0.
REQ-014 In GRANT, if req[owner]=0 at an edge, the block SHALL go to IDLE, clear gnt, and set ptr=owner+1 mod 4 (wrap 3->0).
REQ-015 Every release SHALL be followed by at least one IDLE cycle; no back-to-back grants.
REQ-016 hcnt SHALL load 1 on entering GRANT and increment each further GRANT cycle, saturating at MAX_HOLD.
REQ-017 enabler falling during GRANT SHALL NOT revoke the grant.
REQ-018 Requests from non-owners during GRANT SHALL be ignored until the next IDLE arbitration.
REQ-019 req bits may change at any time; only sampled values at edges are used.

Reset
REQ-020 While rst_n=0: state=IDLE, ptr=0, hcnt=0, gnt=4'b0000, gnt_id=2'b00, busy=0, asynchronously.
REQ-021 Reset asserted mid-grant SHALL drop gnt immediately without waiting for a clock; the first arbitration after reset SHALL start from ptr=0.

Configuration
REQ-022 Macro ARB_HOLD_LIMIT_EN SHALL control the forced release.
REQ-023 With ARB_HOLD_LIMIT_EN defined: in GRANT with hcnt=MAX_HOLD and any other req bit high, the block SHALL go to IDLE and set ptr=owner+1 mod 4, regardless of req[owner].
REQ-024 With ARB_HOLD_LIMIT_EN defined and no other requester pending, the grant SHALL continue with hcnt saturated.
REQ-025 Without ARB_HOLD_LIMIT_EN: hcnt logic SHALL be absent, and grants end only per REQ-014; MAX_HOLD is ignored.

Structure
REQ-026 A shared package SHALL hold the state encoding constants (IDLE=0, GRANT=1), the requester count NUM_REQ=4 and the index width 2.
REQ-027 The one-hot grant SHALL be produced by one sub-module, grant_decode_2to4 (2-bit index plus enable in, 4-bit one-hot out).

Verification
REQ-028 Reset then req=4'b0101, enabler=1: one cycle later gnt=0001, gnt_id=0; drop req[0] -> IDLE gap -> gnt=0100, gnt_id=2.
REQ-029 Wrap-around: owner 3 releases with req=4'b1001 -> ptr=0, next gnt=0001; with owner 2 releasing, req=4'b1001 -> next gnt=1000.
REQ-030 ARB_HOLD_LIMIT_EN, MAX_HOLD=4, req=4'b0011 held: gnt=0001 for 4 cycles, 1 idle cycle, gnt=0010 for 4 cycles, idle, gnt=0001.
REQ-031 ARB_HOLD_LIMIT_EN, only req[2] high for 20 cycles: gnt=0100 continuously, busy never drops.
REQ-032 enabler=0 with req=4'b1111: gnt stays 0; enabler dropped during grant of 1 -> gnt=0010 holds until req[1] falls.
REQ-033 rst_n pulsed low mid-grant of 2: gnt=0 without a clock edge; after release with req=4'b0100, next grant 0100 via ptr=0 search.
